axi4_rd_mix_interconnect_m2s: RTL and testbench
===============================================

// Module: axi4_rd_mix_interconnect_m2s
// PURPOSE
//  Read-side companion of the write mix interconnect. Merges NUM upstream AXI4 read masters onto one
//  downstream read port. Round-robin AR arbitration; upstream port index is prepended to ARID.
//  R beats are routed back by the RID prefix. Upstream ports may issue further ARs without waiting
//  for earlier bursts to finish (multiple outstanding per port, bounded by MAX_OUT).
// PARAMETERS
//  NUM      8    number of upstream read masters (>=2); NSIZE = $clog2(NUM)
//  IDW      4    upstream ID width; downstream ID width = IDW+NSIZE
//  ADDRW    32   address width
//  DATAW    256  read data width
//  MAX_OUT  8    max outstanding bursts per upstream port (>=1)
// PORTS
//  axi_aclk     in   1              clock
//  axi_aresetn  in   1              asynchronous reset, active-low
//  s_arvalid    in   NUM            per-port AR valid
//  s_arready    out  NUM            per-port AR ready
//  s_arid       in   NUM*IDW        per-port ARID, port i at [i*IDW +: IDW]
//  s_araddr     in   NUM*ADDRW      per-port ARADDR
//  s_arlen      in   NUM*8          per-port ARLEN
//  s_arsize     in   NUM*3          per-port ARSIZE
//  s_arburst    in   NUM*2          per-port ARBURST
//  s_rvalid     out  NUM            per-port R valid (one-hot or zero)
//  s_rready     in   NUM            per-port R ready
//  s_rid        out  IDW            R ID, shared by all ports (prefix stripped)
//  s_rdata      out  DATAW          R data, shared
//  s_rresp      out  2              R resp, shared
//  s_rlast      out  1              R last, shared
//  m_arvalid / m_arready  out / in  1    downstream AR handshake
//  m_arid       out  IDW+NSIZE      {grant_idx, s_arid[grant]}
//  m_araddr / m_arlen / m_arsize / m_arburst  out  ADDRW/8/3/2  muxed from the granted port
//  m_rvalid / m_rready    in / out  1    downstream R handshake
//  m_rid        in   IDW+NSIZE      downstream RID; top NSIZE bits select the port
//  m_rdata / m_rresp / m_rlast  in  DATAW/2/1  downstream R payload
//  route_err    out  1              sticky: R beat received with prefix >= NUM
// BEHAVIOUR
//  Reset: m_arvalid=0, s_arready=0, s_rvalid=0, route_err=0, all outstanding counters=0,
//   last_grant=NUM-1 (port 0 has priority first), AR FSM=IDLE, R slice empty.
//  AR FSM IDLE: candidate set = {i : s_arvalid[i] && cnt[i]<MAX_OUT}. If non-empty, grant the first
//   index searching upward from last_grant+1 (mod NUM); register g; go to GRANT. Otherwise stay IDLE.
//  AR FSM GRANT: m_arvalid=1; m_ar* = port g fields; m_arid={g,s_arid[g]}; s_arready[g]=m_arready
//   (combinational); all other s_arready=0. On m_arready: last_grant<=g, cnt[g]++, return to IDLE.
//   Each granted AR costs at least 2 cycles (1 bubble). The granted port must hold arvalid (AXI rule).
//  R slice: single register stage; 1-cycle latency, full throughput.
//   m_rready = !r_full || r_out_fire. Load on m_rvalid&&m_rready. dst = held rid[IDW+NSIZE-1:IDW].
//   s_rvalid[i] = r_full && dst==i. s_rid = held rid[IDW-1:0]. r_out_fire = s_rvalid[dst]&&s_rready[dst].
//   A held beat stays stable until accepted. Simultaneous load+drain is allowed (no bubble).
//  Outstanding: cnt[i] -1 on an upstream R handshake with rlast on port i. On the same cycle as an
//   AR increment, cnt[i] is unchanged. cnt never exceeds MAX_OUT; a port at MAX_OUT is excluded
//   from arbitration.
//  Bad route (dst>=NUM, only possible when NUM is not a power of 2): the beat is drained without
//   asserting any s_rvalid, and route_err<=1 (cleared only by reset).
//  R beats of different bursts/ports may interleave as returned downstream; there is no reordering.
//  Reset mid-operation: all in-flight state is discarded. The downstream slave must be reset together.
// TESTING
//  1 single AR port 2, id=3, len=3 -> m_arid={3'd2,4'd3}; 4 R beats with rid=0x23 appear on s_rvalid[2] only,
//    each 1 cycle after m_r handshake; cnt[2] back to 0 after rlast.
//  2 all 8 ports arvalid continuously -> grants in order 0,1,...,7,0; one m_ar handshake per 2 cycles
//    with m_arready=1.
//  3 port 0 issues 8 ARs with no R returned (MAX_OUT=8) -> 9th AR not granted until one rlast delivered.
//  4 s_rready[5]=0 while a beat for port 5 is held -> m_rready=0, beat stable; release -> drains,
//    back-to-back thereafter.
//  5 interleaved R beats for ports 1 and 6 -> each routed correctly; rlast on port 1 decrements only cnt[1].
//  6 NUM=6, inject rid prefix 7 -> beat consumed, no s_rvalid, route_err=1; assert reset mid-burst
//    -> all outputs return to reset values.

Source files
------------

// File: rtl/axi4_rd_mix_interconnect_m2s.sv
// Merges NUM AXI4 read masters onto one downstream read port: round-robin AR with a port-index ID prefix, R routed back by that prefix.
// AR costs 2 cycles per grant; the R path is a 1-cycle register slice that stalls m_rready while a held beat waits on its port's rready.
module axi4_rd_mix_interconnect_m2s #(
  parameter int NUM     = 8,
  parameter int IDW     = 4,
  parameter int ADDRW   = 32,
  parameter int DATAW   = 256,
  parameter int MAX_OUT = 8,
  localparam int NSIZE  = $clog2(NUM),
  localparam int DIDW   = IDW + NSIZE
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic [NUM-1:0]         s_arvalid,
  output logic [NUM-1:0]         s_arready,
  input  logic [NUM*IDW-1:0]     s_arid,
  input  logic [NUM*ADDRW-1:0]   s_araddr,
  input  logic [NUM*8-1:0]       s_arlen,
  input  logic [NUM*3-1:0]       s_arsize,
  input  logic [NUM*2-1:0]       s_arburst,
  output logic [NUM-1:0]         s_rvalid,
  input  logic [NUM-1:0]         s_rready,
  output logic [IDW-1:0]         s_rid,
  output logic [DATAW-1:0]       s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [DIDW-1:0]        m_arid,
  output logic [ADDRW-1:0]       m_araddr,
  output logic [7:0]             m_arlen,
  output logic [2:0]             m_arsize,
  output logic [1:0]             m_arburst,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [DIDW-1:0]        m_rid,
  input  logic [DATAW-1:0]       m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  output logic                   route_err
);
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [NSIZE-1:0] g, last_grant, pick, idx;
  logic             found;
  logic [NUM-1:0]   cand, inc, dec;
  logic [CW-1:0]    cnt [NUM];

  logic             r_full, r_last, r_out_fire, dst_ok;
  logic [DIDW-1:0]  r_id;
  logic [DATAW-1:0] r_data;
  logic [1:0]       r_resp;
  logic [NSIZE-1:0] dst;

  always_comb begin
    for (int i = 0; i < NUM; i++) cand[i] = s_arvalid[i] && (int'(cnt[i]) < MAX_OUT);
  end

  // First eligible port strictly after the previous winner, wrapping at NUM.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM; k++) begin
      idx = NSIZE'((int'(last_grant) + k) % NUM);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= NSIZE'(NUM - 1);
      m_arvalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          g         <= pick;
          m_arvalid <= 1'b1;
          state     <= GRANT;
        end
        GRANT: if (m_arready) begin
          last_grant <= g;
          m_arvalid  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_arready = '0;
    if (m_arvalid) s_arready[g] = m_arready;
  end

  assign m_arid    = {g, s_arid[int'(g)*IDW +: IDW]};
  assign m_araddr  = s_araddr[int'(g)*ADDRW +: ADDRW];
  assign m_arlen   = s_arlen[int'(g)*8 +: 8];
  assign m_arsize  = s_arsize[int'(g)*3 +: 3];
  assign m_arburst = s_arburst[int'(g)*2 +: 2];

  assign dst    = r_id[DIDW-1:IDW];
  assign dst_ok = int'(dst) < NUM;
  assign s_rid  = r_id[IDW-1:0];
  assign s_rdata = r_data;
  assign s_rresp = r_resp;
  assign s_rlast = r_last;

  // An unroutable beat drains on its own so it cannot wedge the return path.
  always_comb begin
    r_out_fire = r_full && !dst_ok;
    for (int i = 0; i < NUM; i++) begin
      s_rvalid[i] = r_full && (int'(dst) == i);
      if (s_rvalid[i] && s_rready[i]) r_out_fire = 1'b1;
    end
  end

  assign m_rready = !r_full || r_out_fire;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_full    <= 1'b0;
      r_id      <= '0;
      r_data    <= '0;
      r_resp    <= '0;
      r_last    <= 1'b0;
      route_err <= 1'b0;
    end else begin
      if (m_rvalid && m_rready) begin
        r_full <= 1'b1;
        r_id   <= m_rid;
        r_data <= m_rdata;
        r_resp <= m_rresp;
        r_last <= m_rlast;
      end else if (r_out_fire) begin
        r_full <= 1'b0;
      end
      if (r_full && !dst_ok) route_err <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      inc[i] = m_arvalid && m_arready && (int'(g) == i);
      dec[i] = s_rvalid[i] && s_rready[i] && r_last;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (inc[i] && !dec[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_axi4_rd_mix_interconnect_m2s.sv
// Bench for the read mix interconnect: directed scenarios plus a randomized run against a queue-based reference model.
module tb_axi4_rd_mix_interconnect_m2s;
  localparam int NUM = 8, IDW = 4, ADDRW = 32, DATAW = 256, MAX_OUT = 8, DIDW = 7, NB = 6;

  typedef struct {logic [DIDW-1:0] id; int left;} burst_t;
  typedef struct {int port; logic [IDW-1:0] id; logic [DATAW-1:0] data; logic [1:0] resp; logic last;} beat_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NUM-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NUM*IDW-1:0] s_arid;
  logic [NUM*ADDRW-1:0] s_araddr;
  logic [NUM*8-1:0] s_arlen;
  logic [NUM*3-1:0] s_arsize;
  logic [NUM*2-1:0] s_arburst;
  logic [IDW-1:0] s_rid;
  logic [DATAW-1:0] s_rdata, m_rdata;
  logic [1:0] s_rresp, m_rresp, m_arburst;
  logic s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, route_err;
  logic [DIDW-1:0] m_arid, m_rid;
  logic [ADDRW-1:0] m_araddr;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize;

  logic [NB-1:0] b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready;
  logic [NB*IDW-1:0] b_s_arid;
  logic [NB*ADDRW-1:0] b_s_araddr;
  logic [NB*8-1:0] b_s_arlen;
  logic [NB*3-1:0] b_s_arsize;
  logic [NB*2-1:0] b_s_arburst;
  logic [IDW-1:0] b_s_rid;
  logic [DATAW-1:0] b_s_rdata, b_m_rdata;
  logic [1:0] b_s_rresp, b_m_rresp, b_m_arburst;
  logic b_s_rlast, b_m_arvalid, b_m_arready, b_m_rvalid, b_m_rready, b_m_rlast, b_route_err;
  logic [DIDW-1:0] b_m_arid, b_m_rid;
  logic [ADDRW-1:0] b_m_araddr;
  logic [7:0] b_m_arlen;
  logic [2:0] b_m_arsize;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  axi4_rd_mix_interconnect_m2s u_dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .route_err(route_err));

  axi4_rd_mix_interconnect_m2s #(.NUM(NB)) u6 (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_arvalid(b_s_arvalid), .s_arready(b_s_arready), .s_arid(b_s_arid), .s_araddr(b_s_araddr),
    .s_arlen(b_s_arlen), .s_arsize(b_s_arsize), .s_arburst(b_s_arburst),
    .s_rvalid(b_s_rvalid), .s_rready(b_s_rready), .s_rid(b_s_rid), .s_rdata(b_s_rdata),
    .s_rresp(b_s_rresp), .s_rlast(b_s_rlast),
    .m_arvalid(b_m_arvalid), .m_arready(b_m_arready), .m_arid(b_m_arid), .m_araddr(b_m_araddr),
    .m_arlen(b_m_arlen), .m_arsize(b_m_arsize), .m_arburst(b_m_arburst),
    .m_rvalid(b_m_rvalid), .m_rready(b_m_rready), .m_rid(b_m_rid), .m_rdata(b_m_rdata),
    .m_rresp(b_m_rresp), .m_rlast(b_m_rlast), .route_err(b_route_err));

  task automatic clear_inputs;
    s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    b_s_arvalid = '0; b_s_arid = '0; b_s_araddr = '0; b_s_arlen = '0; b_s_arsize = '0; b_s_arburst = '0;
    b_s_rready = '0; b_m_arready = 1'b0; b_m_rvalid = 1'b0; b_m_rid = '0; b_m_rdata = '0; b_m_rresp = '0; b_m_rlast = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Request on port p with m_arready assumed high; returns at the negedge after the handshake.
  task automatic issue_ar(input int p, input logic [IDW-1:0] id, input logic [ADDRW-1:0] addr,
                          input logic [7:0] len, output bit ok, output logic [DIDW-1:0] arid,
                          output logic [ADDRW-1:0] araddr, output logic [7:0] arlen);
    s_arvalid[p] = 1'b1; s_arid[p*IDW +: IDW] = id; s_araddr[p*ADDRW +: ADDRW] = addr; s_arlen[p*8 +: 8] = len;
    ok = 1'b0; arid = '0; araddr = '0; arlen = '0;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (s_arready[p]) begin ok = 1'b1; arid = m_arid; araddr = m_araddr; arlen = m_arlen; end
      @(negedge clk);
    end
    s_arvalid[p] = 1'b0;
  endtask

  // Presents one downstream beat; returns at the negedge after it was loaded into the slice.
  task automatic send_r(input logic [DIDW-1:0] rid, input logic [DATAW-1:0] data, input bit last, output bit ok);
    m_rvalid = 1'b1; m_rid = rid; m_rdata = data; m_rresp = 2'(rid); m_rlast = last;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (m_rready) ok = 1'b1;
      @(negedge clk);
    end
    m_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++; if ({m_arvalid, s_arready, s_rvalid} !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {m_arvalid, s_arready, s_rvalid}); end
    checks++; if ({route_err, b_route_err} !== 2'b00) begin errors++; $display("FAIL reset_route_err got %b exp 00", {route_err, b_route_err}); end
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL reset_m_rready got %b exp 1", m_rready); end
    for (int i = 0; i < NUM; i++) begin
      checks++; if (u_dut.cnt[i] !== '0) begin errors++; $display("FAIL reset_cnt%0d got %0d exp 0", i, u_dut.cnt[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok; logic [DIDW-1:0] arid; logic [ADDRW-1:0] araddr, addr; logic [7:0] arlen; logic [DATAW-1:0] d;
    do_reset();
    m_arready = 1'b1; s_rready = '1; addr = $urandom;
    issue_ar(2, 4'd3, addr, 8'd3, ok, arid, araddr, arlen);
    checks++; if (!ok) begin errors++; $display("FAIL single_ar_hs got 0 exp 1"); end
    checks++; if ({arid, araddr, arlen} !== {7'h23, addr, 8'd3}) begin errors++; $display("FAIL single_ar_fields got %h/%h/%0d exp 23/%h/3", arid, araddr, arlen, addr); end
    checks++; if (u_dut.cnt[2] !== 4'd1) begin errors++; $display("FAIL single_cnt_inc got %0d exp 1", u_dut.cnt[2]); end
    for (int b = 0; b < 4; b++) begin
      d = {8{$urandom}};
      send_r(7'h23, d, b == 3, ok);
      checks++; if (!ok || s_rvalid !== 8'b0000_0100 || s_rid !== 4'd3 || s_rdata !== d || s_rlast !== (b == 3))
        begin errors++; $display("FAIL single_beat%0d got v=%b id=%0d last=%b exp v=00000100 id=3 last=%0d", b, s_rvalid, s_rid, s_rlast, b == 3); end
    end
    @(negedge clk);
    checks++; if (s_rvalid !== '0 || u_dut.cnt[2] !== 4'd0) begin errors++; $display("FAIL single_done got v=%b cnt=%0d exp 0/0", s_rvalid, u_dut.cnt[2]); end
  endtask

  task automatic test_round_robin;
    int n = 0, last_cyc = -1, p;
    do_reset();
    m_arready = 1'b1; s_arvalid = '1;
    for (int i = 0; i < NUM; i++) s_arid[i*IDW +: IDW] = 4'(i);
    for (int cyc = 0; cyc < 24; cyc++) begin
      #1;
      if (m_arvalid && m_arready) begin
        p = int'(m_arid[DIDW-1:IDW]);
        if (n < 9) begin
          checks++; if (p != n % NUM || s_arready !== (NUM'(1) << p) || m_arid[IDW-1:0] !== 4'(p))
            begin errors++; $display("FAIL rr_grant%0d got port %0d rdy=%b exp port %0d", n, p, s_arready, n % NUM); end
          if (last_cyc >= 0) begin
            checks++; if (cyc - last_cyc != 2) begin errors++; $display("FAIL rr_spacing%0d got %0d exp 2", n, cyc - last_cyc); end
          end
        end
        last_cyc = cyc; n++;
      end
      @(negedge clk);
    end
    checks++; if (n < 9) begin errors++; $display("FAIL rr_count got %0d exp >=9", n); end
    s_arvalid = '0;
  endtask

  task automatic test_max_out;
    int n = 0; bit ok, got = 0;
    do_reset();
    m_arready = 1'b1; s_rready = '1; s_arvalid[0] = 1'b1; s_arid[3:0] = 4'd5;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1; if (m_arvalid && m_arready) n++;
      @(negedge clk);
    end
    checks++; if (n != MAX_OUT) begin errors++; $display("FAIL maxout_count got %0d exp %0d", n, MAX_OUT); end
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL maxout_blocked got %b exp 0", m_arvalid); end
    send_r({3'd0, 4'd5}, {8{$urandom}}, 1'b1, ok);
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      #1; if (s_arready[0]) got = 1'b1;
      @(negedge clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL maxout_regrant got 0 exp 1"); end
    s_arvalid = '0;
  endtask

  task automatic test_backpressure;
    bit ok; logic [DATAW-1:0] da, db; logic [DATAW-1:0] ds [5]; int ps [5];
    do_reset();
    s_rready = 8'hDF; da = {8{$urandom}}; db = {8{$urandom}};
    send_r({3'd5, 4'd1}, da, 1'b0, ok);
    checks++; if (s_rvalid !== 8'h20 || s_rdata !== da) begin errors++; $display("FAIL bp_held got v=%b exp 00100000", s_rvalid); end
    m_rvalid = 1'b1; m_rid = {3'd5, 4'd2}; m_rdata = db; m_rlast = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (m_rready !== 1'b0 || s_rdata !== da || s_rid !== 4'd1) begin errors++; $display("FAIL bp_stall%0d got rdy=%b id=%0d exp rdy=0 id=1", c, m_rready, s_rid); end
      @(negedge clk);
    end
    s_rready = '1; #1;
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", m_rready); end
    @(negedge clk);
    checks++; if (s_rdata !== db || s_rid !== 4'd2 || s_rvalid !== 8'h20) begin errors++; $display("FAIL bp_next got id=%0d v=%b exp id=2 v=00100000", s_rid, s_rvalid); end
    for (int k = 0; k < 5; k++) begin
      ds[k] = {8{$urandom}}; ps[k] = $urandom_range(0, NUM-1);
      m_rid = {3'(ps[k]), 4'(k)}; m_rdata = ds[k]; #1;
      checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d got 0 exp 1", k); end
      @(negedge clk);
      checks++; if (s_rdata !== ds[k] || s_rvalid !== (NUM'(1) << ps[k]) || s_rid !== 4'(k))
        begin errors++; $display("FAIL b2b_beat%0d got v=%b id=%0d exp port %0d id=%0d", k, s_rvalid, s_rid, ps[k], k); end
    end
    m_rvalid = 1'b0;
  endtask

  task automatic test_interleave;
    bit ok; logic [DIDW-1:0] arid; logic [ADDRW-1:0] araddr; logic [7:0] arlen; logic [DATAW-1:0] d;
    int bp [4] = '{1, 6, 1, 6}; bit bl [4] = '{0, 0, 1, 1};
    do_reset();
    m_arready = 1'b1; s_rready = '1;
    issue_ar(1, 4'd9, $urandom, 8'd1, ok, arid, araddr, arlen);
    issue_ar(6, 4'd4, $urandom, 8'd1, ok, arid, araddr, arlen);
    checks++; if (u_dut.cnt[1] !== 4'd1 || u_dut.cnt[6] !== 4'd1) begin errors++; $display("FAIL il_cnt_start got %0d/%0d exp 1/1", u_dut.cnt[1], u_dut.cnt[6]); end
    for (int b = 0; b < 4; b++) begin
      d = {8{$urandom}};
      send_r({3'(bp[b]), (bp[b] == 1) ? 4'd9 : 4'd4}, d, bl[b], ok);
      checks++; if (s_rvalid !== (NUM'(1) << bp[b]) || s_rdata !== d || s_rid !== ((bp[b] == 1) ? 4'd9 : 4'd4))
        begin errors++; $display("FAIL il_beat%0d got v=%b id=%0d exp port %0d", b, s_rvalid, s_rid, bp[b]); end
      if (b == 2) begin
        @(negedge clk);
        checks++; if (u_dut.cnt[1] !== 4'd0 || u_dut.cnt[6] !== 4'd1) begin errors++; $display("FAIL il_cnt_mid got %0d/%0d exp 0/1", u_dut.cnt[1], u_dut.cnt[6]); end
      end
    end
    @(negedge clk);
    checks++; if (u_dut.cnt[6] !== 4'd0) begin errors++; $display("FAIL il_cnt_end got %0d exp 0", u_dut.cnt[6]); end
  endtask

  task automatic test_bad_route_and_reset;
    bit ok;
    do_reset();
    b_s_rready = '1;
    b_m_rvalid = 1'b1; b_m_rid = {3'd7, 4'd2}; b_m_rdata = {8{$urandom}}; #1;
    checks++; if (b_m_rready !== 1'b1) begin errors++; $display("FAIL bad_accept got %b exp 1", b_m_rready); end
    @(negedge clk);
    b_m_rvalid = 1'b0;
    checks++; if (b_s_rvalid !== '0) begin errors++; $display("FAIL bad_no_valid got %b exp 0", b_s_rvalid); end
    @(negedge clk);
    checks++; if (b_route_err !== 1'b1 || b_s_rvalid !== '0 || b_m_rready !== 1'b1) begin errors++; $display("FAIL bad_err got err=%b v=%b exp err=1 v=0", b_route_err, b_s_rvalid); end
    b_m_rvalid = 1'b1; b_m_rid = {3'd5, 4'd1}; #1;
    @(negedge clk);
    b_m_rvalid = 1'b0;
    checks++; if (b_s_rvalid !== 6'b10_0000 || b_route_err !== 1'b1) begin errors++; $display("FAIL bad_then_good got v=%b err=%b exp 100000/1", b_s_rvalid, b_route_err); end
    // Park a pending AR grant and a held beat, then pull reset mid-cycle.
    s_arvalid[3] = 1'b1; s_rready = 8'hEF;
    send_r({3'd4, 4'd7}, {8{$urandom}}, 1'b0, ok);
    m_rvalid = 1'b1; m_rid = {3'd2, 4'd0};
    @(negedge clk);
    checks++; if (m_arvalid !== 1'b1 || s_rvalid !== 8'h10) begin errors++; $display("FAIL mid_pre got arv=%b v=%b exp 1/00010000", m_arvalid, s_rvalid); end
    #2 rst_n = 1'b0; #1;
    checks++; if ({m_arvalid, s_arready, s_rvalid, route_err, b_route_err} !== '0 || m_rready !== 1'b1)
      begin errors++; $display("FAIL mid_reset got arv=%b ardy=%b v=%b err=%b%b rrdy=%b exp all 0 rrdy=1", m_arvalid, s_arready, s_rvalid, route_err, b_route_err, m_rready); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random;
    bit pend [NUM]; logic [IDW-1:0] pid [NUM]; logic [ADDRW-1:0] paddr [NUM]; logic [7:0] plen [NUM]; logic [2:0] psize [NUM];
    int mcnt [NUM]; burst_t bq [$]; beat_t eq [$]; beat_t nb; burst_t nbur;
    bit cur_v = 0, done = 0, any; int cur_idx = 0, nbeats = 0, p;
    logic [DIDW-1:0] cur_id = '0; logic [DATAW-1:0] cur_data = '0; logic [1:0] cur_resp = '0; logic cur_last = 1'b0;
    logic [NUM-1:0] exp_v;
    do_reset();
    for (int i = 0; i < NUM; i++) begin pend[i] = 0; mcnt[i] = 0; pid[i] = '0; paddr[i] = '0; plen[i] = '0; psize[i] = '0; end
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      for (int i = 0; i < NUM; i++) begin
        if (!pend[i] && cyc < 1500 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1; pid[i] = 4'($urandom); paddr[i] = $urandom; plen[i] = 8'($urandom_range(0, 3)); psize[i] = 3'($urandom);
        end
        s_arvalid[i] = pend[i]; s_arid[i*IDW +: IDW] = pid[i]; s_araddr[i*ADDRW +: ADDRW] = paddr[i];
        s_arlen[i*8 +: 8] = plen[i]; s_arsize[i*3 +: 3] = psize[i];
      end
      m_arready = ($urandom_range(0, 3) != 0);
      s_rready = NUM'($urandom);
      if (!cur_v && bq.size() > 0 && $urandom_range(0, 2) != 0) begin
        cur_idx = $urandom_range(0, bq.size() - 1); cur_id = bq[cur_idx].id;
        cur_data = {8{$urandom}}; cur_resp = 2'($urandom); cur_last = (bq[cur_idx].left == 1); cur_v = 1;
      end
      m_rvalid = cur_v; m_rid = cur_id; m_rdata = cur_data; m_rresp = cur_resp; m_rlast = cur_last;
      #1;
      exp_v = (eq.size() > 0) ? (NUM'(1) << eq[0].port) : '0;
      checks++; if (s_rvalid !== exp_v) begin errors++; $display("FAIL rnd_rvalid cyc %0d got %b exp %b", cyc, s_rvalid, exp_v); end
      if (eq.size() > 0) begin
        checks++; if ({s_rid, s_rdata, s_rresp, s_rlast} !== {eq[0].id, eq[0].data, eq[0].resp, eq[0].last})
          begin errors++; $display("FAIL rnd_rbeat cyc %0d got id=%0d last=%b exp id=%0d last=%b", cyc, s_rid, s_rlast, eq[0].id, eq[0].last); end
        if (s_rready[eq[0].port]) begin
          if (eq[0].last) mcnt[eq[0].port]--;
          nbeats++; void'(eq.pop_front());
        end
      end
      if (m_arvalid && m_arready) begin
        p = int'(m_arid[DIDW-1:IDW]);
        checks++; if (p >= NUM || !pend[p] || mcnt[p] >= MAX_OUT || s_arready !== (NUM'(1) << p))
          begin errors++; $display("FAIL rnd_grant cyc %0d got port %0d rdy=%b", cyc, p, s_arready); end
        else begin
          checks++; if ({m_arid[IDW-1:0], m_araddr, m_arlen, m_arsize} !== {pid[p], paddr[p], plen[p], psize[p]})
            begin errors++; $display("FAIL rnd_arfields cyc %0d got %h/%h/%0d exp %h/%h/%0d", cyc, m_arid, m_araddr, m_arlen, pid[p], paddr[p], plen[p]); end
          pend[p] = 0; mcnt[p]++;
          nbur.id = m_arid; nbur.left = int'(plen[p]) + 1; bq.push_back(nbur);
        end
      end
      if (cur_v && m_rready) begin
        nb.port = int'(cur_id[DIDW-1:IDW]); nb.id = cur_id[IDW-1:0]; nb.data = cur_data; nb.resp = cur_resp; nb.last = cur_last;
        eq.push_back(nb);
        bq[cur_idx].left--;
        if (bq[cur_idx].left == 0) bq.delete(cur_idx);
        cur_v = 0;
      end
      any = 0;
      for (int i = 0; i < NUM; i++) any |= pend[i];
      done = (cyc >= 1500) && !any && bq.size() == 0 && eq.size() == 0 && !cur_v;
      @(negedge clk);
    end
    s_arvalid = '0; m_rvalid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL rnd_drain got busy exp idle"); end
    checks++; if (nbeats < 200) begin errors++; $display("FAIL rnd_activity got %0d beats exp >=200", nbeats); end
    for (int i = 0; i < NUM; i++) begin
      checks++; if (int'(u_dut.cnt[i]) != mcnt[i] || mcnt[i] != 0) begin errors++; $display("FAIL rnd_cnt%0d got %0d exp %0d", i, u_dut.cnt[i], mcnt[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_max_out();
    test_backpressure();
    test_interleave();
    test_bad_route_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
